ita_step_sequencer: RTL and testbench
=====================================

# ita_step_sequencer

Multi-head step and tile sequencer for ITA. It latches a layer configuration on `start_i` and walks the step sequence for the selected layer mode: Q, K, V, QK, AV, OW per head for attention, F1 then F2 for feedforward, and MatMul for linear. Within each step it nests row, column and inner tile loops. Each tile command goes to the datapath over a valid/ready handshake, together with the requant-constant index for that step. It sits between the control register file and the accumulator/requantizer datapath, and generalises the single-head, fixed-shape step control to a runtime head count and runtime tile counts.

## Interface
- `MaxHeads`, default 4: maximum head count; `n_heads_i` is clamped to this value.
- `TileWidth`, default 32: width of the tile-count inputs and of the tile indices.
- `HeadWidth`, default `idx_width(MaxHeads)`: head index width.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset. One clock; reset is synchronous and active-high.
- `start_i`  in  1  start request. Sampled only in Idle.
- `layer_i`  in  `layer_e`  mode: Attention, Feedforward, Linear, SingleAttention.
- `n_heads_i`  in  HeadWidth+1  head count for Attention mode.
- `tile_s_i`, `tile_e_i`, `tile_p_i`, `tile_f_i`  in  TileWidth each  tile counts.
- `tile_valid_o`  out  1  a tile command is present.
- `tile_ready_i`  in  1  the datapath accepts the command.
- `step_o`  out  `step_e`  current step.
- `head_o`  out  HeadWidth  current head.
- `row_o`, `col_o`, `inner_o`  out  TileWidth each  tile indices.
- `first_inner_o`, `last_inner_o`  out  1 each  inner loop is at its first / last index (accumulator clear / requant flush).
- `requant_idx_o`  out  3  index into the per-step requant arrays.
- `busy_o`  out  1  not Idle.
- `done_o`  out  1  single-cycle completion pulse.
- `cycles_o`, `stalls_o`  out  32 each  performance counters (see Configuration).

## Operation
**States.** `step_e` encoding: Idle, Q, K, V, QK, AV, OW, F1, F2, MatMul.

**Sequences.**
- Attention: for h = 0 to n_heads−1, run Q→K→V→QK→AV→OW. After OW the head increments and the sequence restarts at Q.
- SingleAttention: the same sequence with exactly one head; `n_heads_i` is ignored.
- Feedforward: F1→F2.
- Linear: MatMul only.

**Loop bounds (rows, cols, inner), in tiles.**
- Q/K/V: (s, p, e).
- QK: (s, s, p).
- AV: (s, p, s).
- OW: (s, e, p).
- F1: (s, f, e).
- F2: (s, e, f).
- MatMul: (s, p, e).

**Loop order and step advance.**
- `inner` is the fastest loop, then `col`, then `row`.
- Each handshake (valid && ready) advances the loops.
- The handshake on the last row/col/inner tile of a step advances to the next step with all indices reset to 0.

**requant_idx_o.**
- Q=0, K=1, V=2, QK=3, AV=4, OW=5, F1=6, F2=7.
- MatMul=0.
- Idle=0.

**Configuration latching.**
- Inputs are latched on the cycle `start_i` is accepted.
- Changes to the inputs while busy have no effect.
- `start_i` while busy is ignored.

**Arithmetic and boundaries.**
- Tile counts of 0 are treated as 1.
- `n_heads_i` = 0 is treated as 1; `n_heads_i` > MaxHeads is clamped to MaxHeads.
- Index comparisons use count−1; no counter wraps mid-step.

**Reset values.**
- All outputs 0, `step_o` = Idle.
- `rst_i` asserted mid-operation returns to Idle on the next edge: no `done_o`, command dropped.

## Timing
- Start latency: `start_i` accepted at cycle t gives `tile_valid_o` = 1 at t+1 with the first command (Q or F1 or MatMul, all indices 0, `first_inner_o` = 1).
- Stability: command outputs hold stable while `tile_valid_o` && !`tile_ready_i`. `tile_valid_o` never drops without a handshake, except on reset.
- Throughput: with `tile_ready_i` held high, one command is issued per cycle with no bubbles, including across step and head boundaries.
- Completion: the last handshake at cycle t gives `done_o` = 1 and Idle at t+1, with `tile_valid_o` = 0. A `start_i` in that same cycle is accepted, giving the next command at t+2.
- `first_inner_o` / `last_inner_o` are combinational from registered indices and are valid whenever `tile_valid_o` is high.

## Configuration
- `ITA_SEQ_PERF_CNT_EN` defined:
  - `cycles_o` counts cycles with `busy_o` = 1.
  - `stalls_o` counts cycles with `tile_valid_o` && !`tile_ready_i`.
  - Both clear to 0 on an accepted start, saturate at 2^32−1, and hold after done.
- `ITA_SEQ_PERF_CNT_EN` undefined: both ports are tied to 0 and no counter flops are instantiated.

## Test plan
- Linear with s=2, e=3, p=1, ready held high → 6 commands (MatMul, row 0..1, col 0, inner 0..2), `requant_idx_o`=0, `done_o` at cycle 7 after start.
- Feedforward with s=1, e=1, f=2 → F1: 2 commands (col 0..1); F2: 2 commands (inner 0..1, `last_inner_o` on the second); requant 6 then 7; `done_o` one cycle after the 4th handshake.
- Attention with n_heads=2 and all tiles=1 → 12 commands; `head_o` is 0 for the first 6 and 1 for the last 6; steps Q..OW twice; `requant_idx_o` runs 0..5 twice.
- Backpressure: ready toggling 0/1 every cycle on the Linear s=2, e=3, p=1 case → commands stable during stalls; 6 handshakes; with the perf macro, `stalls_o`=6 and `cycles_o`=12.
- Boundaries: tile_s=0 and n_heads=9 with MaxHeads=4 → treated as 1 row and 4 heads; `start_i` pulsed while busy → ignored.
- Reset: `rst_i` asserted mid-QK → next cycle Idle, all outputs 0, no `done_o`; a fresh start then runs normally.

Source files
------------

// File: rtl/ita_step_sequencer.sv
// rtl/ita_step_sequencer.sv - multi-head step and tile sequencer for ITA
//
// Walks the per-layer step sequence (Q,K,V,QK,AV,OW per head / F1,F2 / MatMul)
// and nests row, col and inner tile loops inside each step. Every tile command
// is offered to the datapath over a valid/ready handshake together with the
// requant-constant index for the step.
//
// Optional feature macro: ITA_SEQ_PERF_CNT_EN (busy-cycle and stall counters).
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i                      start request, sampled only in Idle
//   layer_i                      layer mode
//   n_heads_i                    head count for Attention (0 -> 1, clamped to MaxHeads)
//   tile_s_i/e_i/p_i/f_i         tile counts (0 treated as 1)
//   tile_valid_o, tile_ready_i   command handshake
//   step_o, head_o               current step and head
//   row_o, col_o, inner_o        current tile indices
//   first_inner_o, last_inner_o  inner loop at first / last index
//   requant_idx_o                index into per-step requant arrays
//   busy_o, done_o               not Idle / one-cycle completion pulse
//   cycles_o, stalls_o           performance counters (0 when feature disabled)

package ita_seq_pkg;

  typedef enum logic [1:0] {
    LAYER_ATTENTION,
    LAYER_FEEDFORWARD,
    LAYER_LINEAR,
    LAYER_SINGLE_ATTENTION
  } layer_e;

  typedef enum logic [3:0] {
    STEP_IDLE,
    STEP_Q,
    STEP_K,
    STEP_V,
    STEP_QK,
    STEP_AV,
    STEP_OW,
    STEP_F1,
    STEP_F2,
    STEP_MATMUL
  } step_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

module ita_step_sequencer
  import ita_seq_pkg::*;
#(
  parameter int unsigned MaxHeads  = 4,
  parameter int unsigned TileWidth = 32,
  parameter int unsigned HeadWidth = idx_width(MaxHeads)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  layer_e               layer_i,
  input  logic [HeadWidth:0]   n_heads_i,
  input  logic [TileWidth-1:0] tile_s_i,
  input  logic [TileWidth-1:0] tile_e_i,
  input  logic [TileWidth-1:0] tile_p_i,
  input  logic [TileWidth-1:0] tile_f_i,
  output logic                 tile_valid_o,
  input  logic                 tile_ready_i,
  output step_e                step_o,
  output logic [HeadWidth-1:0] head_o,
  output logic [TileWidth-1:0] row_o,
  output logic [TileWidth-1:0] col_o,
  output logic [TileWidth-1:0] inner_o,
  output logic                 first_inner_o,
  output logic                 last_inner_o,
  output logic [2:0]           requant_idx_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [31:0]          cycles_o,
  output logic [31:0]          stalls_o
);

  // Counts are stored as (count-1) so loop-end tests are plain equality.
  function automatic logic [TileWidth-1:0] count_m1(input logic [TileWidth-1:0] c);
    return (c == '0) ? '0 : c - TileWidth'(1);
  endfunction

  step_e                step_q, step_d;
  logic [HeadWidth-1:0] head_q, head_d;
  logic [TileWidth-1:0] row_q, row_d, col_q, col_d, inner_q, inner_d;
  logic [TileWidth-1:0] s_m1_q, s_m1_d, e_m1_q, e_m1_d, p_m1_q, p_m1_d, f_m1_q, f_m1_d;
  logic [HeadWidth-1:0] heads_m1_q, heads_m1_d;
  logic                 done_q, done_d;

  logic                 busy;
  logic                 handshake;
  logic [HeadWidth:0]   n_heads_clamped;
  logic [TileWidth-1:0] rows_m1, cols_m1, inner_m1;

  assign busy      = (step_q != STEP_IDLE);
  assign handshake = busy && tile_ready_i;

  // Loop bounds of the current step.
  always_comb begin
    rows_m1  = s_m1_q;
    cols_m1  = '0;
    inner_m1 = '0;
    case (step_q)
      STEP_Q, STEP_K, STEP_V, STEP_MATMUL: begin cols_m1 = p_m1_q; inner_m1 = e_m1_q; end
      STEP_QK: begin cols_m1 = s_m1_q; inner_m1 = p_m1_q; end
      STEP_AV: begin cols_m1 = p_m1_q; inner_m1 = s_m1_q; end
      STEP_OW: begin cols_m1 = e_m1_q; inner_m1 = p_m1_q; end
      STEP_F1: begin cols_m1 = f_m1_q; inner_m1 = e_m1_q; end
      STEP_F2: begin cols_m1 = e_m1_q; inner_m1 = f_m1_q; end
      default: rows_m1 = '0;
    endcase
  end

  always_comb begin
    n_heads_clamped = n_heads_i;
    if (n_heads_i == '0) begin
      n_heads_clamped = (HeadWidth+1)'(1);
    end else if (n_heads_i > (HeadWidth+1)'(MaxHeads)) begin
      n_heads_clamped = (HeadWidth+1)'(MaxHeads);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step_q     <= STEP_IDLE;
      head_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      inner_q    <= '0;
      s_m1_q     <= '0;
      e_m1_q     <= '0;
      p_m1_q     <= '0;
      f_m1_q     <= '0;
      heads_m1_q <= '0;
      done_q     <= 1'b0;
    end else begin
      step_q     <= step_d;
      head_q     <= head_d;
      row_q      <= row_d;
      col_q      <= col_d;
      inner_q    <= inner_d;
      s_m1_q     <= s_m1_d;
      e_m1_q     <= e_m1_d;
      p_m1_q     <= p_m1_d;
      f_m1_q     <= f_m1_d;
      heads_m1_q <= heads_m1_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    step_d     = step_q;
    head_d     = head_q;
    row_d      = row_q;
    col_d      = col_q;
    inner_d    = inner_q;
    s_m1_d     = s_m1_q;
    e_m1_d     = e_m1_q;
    p_m1_d     = p_m1_q;
    f_m1_d     = f_m1_q;
    heads_m1_d = heads_m1_q;
    done_d     = 1'b0;

    if (!busy) begin
      if (start_i) begin
        s_m1_d  = count_m1(tile_s_i);
        e_m1_d  = count_m1(tile_e_i);
        p_m1_d  = count_m1(tile_p_i);
        f_m1_d  = count_m1(tile_f_i);
        head_d  = '0;
        row_d   = '0;
        col_d   = '0;
        inner_d = '0;
        heads_m1_d = '0;
        case (layer_i)
          LAYER_ATTENTION: begin
            step_d     = STEP_Q;
            heads_m1_d = HeadWidth'(n_heads_clamped - (HeadWidth+1)'(1));
          end
          LAYER_SINGLE_ATTENTION: step_d = STEP_Q;
          LAYER_FEEDFORWARD:      step_d = STEP_F1;
          default:                step_d = STEP_MATMUL;
        endcase
      end
    end else if (handshake) begin
      if (inner_q != inner_m1) begin
        inner_d = inner_q + TileWidth'(1);
      end else begin
        inner_d = '0;
        if (col_q != cols_m1) begin
          col_d = col_q + TileWidth'(1);
        end else begin
          col_d = '0;
          if (row_q != rows_m1) begin
            row_d = row_q + TileWidth'(1);
          end else begin
            row_d = '0;
            case (step_q)
              STEP_Q:  step_d = STEP_K;
              STEP_K:  step_d = STEP_V;
              STEP_V:  step_d = STEP_QK;
              STEP_QK: step_d = STEP_AV;
              STEP_AV: step_d = STEP_OW;
              STEP_F1: step_d = STEP_F2;
              STEP_OW: begin
                if (head_q != heads_m1_q) begin
                  head_d = head_q + HeadWidth'(1);
                  step_d = STEP_Q;
                end else begin
                  head_d = '0;
                  step_d = STEP_IDLE;
                  done_d = 1'b1;
                end
              end
              default: begin
                head_d = '0;
                step_d = STEP_IDLE;
                done_d = 1'b1;
              end
            endcase
          end
        end
      end
    end
  end

  always_comb begin
    requant_idx_o = 3'd0;
    case (step_q)
      STEP_K:  requant_idx_o = 3'd1;
      STEP_V:  requant_idx_o = 3'd2;
      STEP_QK: requant_idx_o = 3'd3;
      STEP_AV: requant_idx_o = 3'd4;
      STEP_OW: requant_idx_o = 3'd5;
      STEP_F1: requant_idx_o = 3'd6;
      STEP_F2: requant_idx_o = 3'd7;
      default: requant_idx_o = 3'd0;
    endcase
  end

  assign tile_valid_o  = busy;
  assign busy_o        = busy;
  assign done_o        = done_q;
  assign step_o        = step_q;
  assign head_o        = head_q;
  assign row_o         = row_q;
  assign col_o         = col_q;
  assign inner_o       = inner_q;
  assign first_inner_o = busy && (inner_q == '0);
  assign last_inner_o  = busy && (inner_q == inner_m1);

`ifdef ITA_SEQ_PERF_CNT_EN
  logic [31:0] cycles_q, stalls_q;
  logic        start_accept;

  assign start_accept = !busy && start_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || start_accept) begin
      cycles_q <= '0;
      stalls_q <= '0;
    end else begin
      if (busy && (cycles_q != '1)) begin
        cycles_q <= cycles_q + 32'd1;
      end
      if (busy && !tile_ready_i && (stalls_q != '1)) begin
        stalls_q <= stalls_q + 32'd1;
      end
    end
  end

  assign cycles_o = cycles_q;
  assign stalls_o = stalls_q;
`else
  assign cycles_o = '0;
  assign stalls_o = '0;
`endif

endmodule

// File: tb/tb_ita_step_sequencer.sv
// tb/tb_ita_step_sequencer.sv - scoreboard bench for ita_step_sequencer
module tb_ita_step_sequencer;
  import ita_seq_pkg::*;

  localparam int TW = 32;
  localparam int HW = 3;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  layer_e        layer;
  logic [HW:0]   n_heads;
  logic [TW-1:0] ts, te, tp, tf;
  logic          ready;
  logic          tile_valid_o;
  step_e         step_o;
  logic [HW-1:0] head_o;
  logic [TW-1:0] row_o, col_o, inner_o;
  logic          first_inner_o, last_inner_o;
  logic [2:0]    requant_idx_o;
  logic          busy_o, done_o;
  logic [31:0]   cycles_o, stalls_o;

  ita_step_sequencer #(.MaxHeads(MH), .TileWidth(TW), .HeadWidth(HW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .layer_i(layer), .n_heads_i(n_heads),
    .tile_s_i(ts), .tile_e_i(te), .tile_p_i(tp), .tile_f_i(tf),
    .tile_valid_o(tile_valid_o), .tile_ready_i(ready), .step_o(step_o), .head_o(head_o),
    .row_o(row_o), .col_o(col_o), .inner_o(inner_o),
    .first_inner_o(first_inner_o), .last_inner_o(last_inner_o),
    .requant_idx_o(requant_idx_o), .busy_o(busy_o), .done_o(done_o),
    .cycles_o(cycles_o), .stalls_o(stalls_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    step_e         step;
    logic [HW-1:0] head;
    logic [TW-1:0] row;
    logic [TW-1:0] col;
    logic [TW-1:0] inner;
    logic          first;
    logic          last;
    logic [2:0]    rq;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_hs = -10;
  cmd_t stall_snap;
  bit   stall_prev = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic cmd_t cur_cmd();
    cmd_t c;
    c.step  = step_o;
    c.head  = head_o;
    c.row   = row_o;
    c.col   = col_o;
    c.inner = inner_o;
    c.first = first_inner_o;
    c.last  = last_inner_o;
    c.rq    = requant_idx_o;
    return c;
  endfunction

  task automatic check(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push(input step_e st, input int h, input int r, input int c, input int i,
                      input bit f, input bit l, input int rq);
    cmd_t e;
    e.step = st; e.head = HW'(h); e.row = TW'(r); e.col = TW'(c); e.inner = TW'(i);
    e.first = f; e.last = l; e.rq = 3'(rq);
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stall stability and done timing.
  always @(negedge clk) begin
    cmd_t c;
    cmd_t e;
    c = cur_cmd();
    if (stall_prev && tile_valid_o) begin
      n_cmp++;
      if (c !== stall_snap) begin
        n_err++;
        $display("FAIL stall_stable: got %h want %h", c, stall_snap);
      end
    end
    stall_prev = tile_valid_o && !ready;
    stall_snap = c;
    if (tile_valid_o && ready) begin
      last_hs = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL cmd_unexpected: got %h want none", c);
      end else begin
        e = exp_q.pop_front();
        if (c !== e) begin
          n_err++;
          $display("FAIL cmd: got %h want %h", c, e);
        end
      end
    end
    if (done_o) begin
      n_cmp++;
      if (cyc != last_hs + 1 || tile_valid_o) begin
        n_err++;
        $display("FAIL done_timing: got cyc %0d valid %0d want cyc %0d valid 0",
                 cyc, tile_valid_o, last_hs + 1);
      end
    end
  end

  // Start is driven in the current cycle; returns one cycle after acceptance.
  task automatic start_run(input layer_e l, input int nh, input int s, input int e,
                           input int p, input int f, input bit toggle, output int t0);
    layer = l; n_heads = (HW+1)'(nh);
    ts = TW'(s); te = TW'(e); tp = TW'(p); tf = TW'(f);
    ready = 1'b1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (toggle) ready = 1'b0;
    check("start_latency_valid", tile_valid_o, 1);
  endtask

  task automatic wait_done(input bit toggle, input int budget, output int dc);
    dc = -1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (toggle) ready = ~ready;
      if (done_o) begin
        dc = cyc;
        break;
      end
    end
    ready = 1'b1;
    if (dc < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got none want done within %0d cycles", budget);
    end
  endtask

  task automatic check_idle(input string name);
    check(name, {tile_valid_o, busy_o, done_o, step_o, head_o, row_o, col_o, inner_o,
                 first_inner_o, last_inner_o, requant_idx_o} == '0, 1);
    check({name, "_perf"}, {cycles_o, stalls_o}, 0);
  endtask

  initial begin
    int t0, dc;
    rst = 1'b1; start = 1'b0; ready = 1'b1; layer = LAYER_LINEAR;
    n_heads = '0; ts = '0; te = '0; tp = '0; tf = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;

    // Linear s=2 e=3 p=1: MatMul rows 0..1, inner 0..2
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 3; i++)
        push(STEP_MATMUL, 0, r, 0, i, i == 0, i == 2, 0);
    start_run(LAYER_LINEAR, 0, 2, 3, 1, 0, 1'b0, t0);
    wait_done(1'b0, 50, dc);
    check("lin_done_cycle", dc - t0, 7);
    check("lin_queue_empty", exp_q.size(), 0);

    // Feedforward s=1 e=1 f=2, started in the done cycle; mid-run start pulse ignored
    push(STEP_F1, 0, 0, 0, 0, 1, 1, 6);
    push(STEP_F1, 0, 0, 1, 0, 1, 1, 6);
    push(STEP_F2, 0, 0, 0, 0, 1, 0, 7);
    push(STEP_F2, 0, 0, 0, 1, 0, 1, 7);
    start_run(LAYER_FEEDFORWARD, 0, 1, 1, 0, 2, 1'b0, t0);
    start = 1'b1; layer = LAYER_LINEAR; ts = 5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, 50, dc);
    check("ff_done_cycle", dc - t0, 5);
    check("ff_queue_empty", exp_q.size(), 0);

    // Attention, 2 heads, all tiles 1
    for (int h = 0; h < 2; h++)
      for (int s = 0; s < 6; s++)
        push(step_e'(int'(STEP_Q) + s), h, 0, 0, 0, 1, 1, s);
    start_run(LAYER_ATTENTION, 2, 1, 1, 1, 1, 1'b0, t0);
    wait_done(1'b0, 50, dc);
    check("att_done_cycle", dc - t0, 13);
    check("att_queue_empty", exp_q.size(), 0);

    // Backpressure: Linear s=2 e=3 p=1 with ready toggling, first valid cycle stalled
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 3; i++)
        push(STEP_MATMUL, 0, r, 0, i, i == 0, i == 2, 0);
    start_run(LAYER_LINEAR, 0, 2, 3, 1, 0, 1'b1, t0);
    wait_done(1'b1, 60, dc);
    check("bp_done_cycle", dc - t0, 13);
    check("bp_queue_empty", exp_q.size(), 0);
`ifdef ITA_SEQ_PERF_CNT_EN
    check("bp_cycles", cycles_o, 12);
    check("bp_stalls", stalls_o, 6);
    @(posedge clk); #1;
    check("bp_cycles_hold", cycles_o, 12);
`else
    check("bp_cycles", cycles_o, 0);
    check("bp_stalls", stalls_o, 0);
`endif

    // Boundaries: tile_s=0 -> 1 row, n_heads=9 -> 4 heads
    for (int h = 0; h < 4; h++)
      for (int s = 0; s < 6; s++)
        push(step_e'(int'(STEP_Q) + s), h, 0, 0, 0, 1, 1, s);
    start_run(LAYER_ATTENTION, 9, 0, 1, 1, 1, 1'b0, t0);
    wait_done(1'b0, 80, dc);
    check("bnd_done_cycle", dc - t0, 25);
    check("bnd_queue_empty", exp_q.size(), 0);

    // SingleAttention ignores n_heads
    for (int s = 0; s < 6; s++)
      push(step_e'(int'(STEP_Q) + s), 0, 0, 0, 0, 1, 1, s);
    start_run(LAYER_SINGLE_ATTENTION, 3, 1, 1, 1, 1, 1'b0, t0);
    wait_done(1'b0, 50, dc);
    check("single_done_cycle", dc - t0, 7);
    check("single_queue_empty", exp_q.size(), 0);

    // Reset during QK
    push(STEP_Q, 0, 0, 0, 0, 1, 1, 0);
    push(STEP_K, 0, 0, 0, 0, 1, 1, 1);
    push(STEP_V, 0, 0, 0, 0, 1, 1, 2);
    start_run(LAYER_ATTENTION, 1, 1, 1, 1, 1, 1'b0, t0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rst_at_qk", step_o, STEP_QK);
    ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("rst_mid_idle");
    @(posedge clk); #1;
    check("rst_no_done", {done_o, busy_o}, 0);
    ready = 1'b1;
    check("rst_queue_empty", exp_q.size(), 0);

    // Fresh start after reset
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 3; i++)
        push(STEP_MATMUL, 0, r, 0, i, i == 0, i == 2, 0);
    start_run(LAYER_LINEAR, 0, 2, 3, 1, 0, 1'b0, t0);
    wait_done(1'b0, 50, dc);
    check("fresh_done_cycle", dc - t0, 7);
    check("fresh_queue_empty", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
